// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for load_store_unit.
// slave is the unit's view; master is the requester/memory environment view.
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              reqValid;
   logic              reqReady;
   logic              reqWrite;
   logic [2:0]        reqFunct3;
   logic [ADDR_W-1:0] reqAddr;
   logic [31:0]       reqData;
   logic              respValid;
   logic              respErr;
   logic [31:0]       loadData;
   logic              memWrite;
   logic              memRead;
   logic [ADDR_W-1:0] memAddr;
   logic [31:0]       memWriteData;
   logic [31:0]       memReadData;

   modport slave (
      input  reqValid, reqWrite, reqFunct3, reqAddr, reqData, memReadData,
      output reqReady, respValid, respErr, loadData,
             memWrite, memRead, memAddr, memWriteData
   );

   modport master (
      output reqValid, reqWrite, reqFunct3, reqAddr, reqData, memReadData,
      input  reqReady, respValid, respErr, loadData,
             memWrite, memRead, memAddr, memWriteData
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only, 1-cycle-read data memory with RISC-V sub-word handling.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module load_store_unit #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS * 4);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

   state_t      state;
   state_t      state_next;
   logic        op_write;
   logic [2:0]  op_funct3;
   logic [1:0]  op_lane;
   logic [15:0] op_data;

   logic        accept_c;
   logic        err_c;
   logic        funct_ok_c;
   logic        range_ok_c;
   logic        align_ok_c;
   logic [7:0]  byte_c;
   logic [15:0] half_c;
   logic [31:0] load_ext_c;
   logic [31:0] merged_c;

   assign accept_c   = (state == IDLE) && bus.reqValid;
   assign range_ok_c = ({1'b0, bus.reqAddr} < MEM_LIMIT);
   assign err_c      = !(funct_ok_c && range_ok_c && align_ok_c);

   // Legal funct3 encodings for the request direction
   always_comb begin
      funct_ok_c = 1'b0;
      if (bus.reqWrite) begin
         funct_ok_c = (bus.reqFunct3 <= 3'b010);
      end else begin
         case (bus.reqFunct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct_ok_c = 1'b1;
            default:                                funct_ok_c = 1'b0;
         endcase
      end
   end

`ifdef LSU_MISALIGN_CHECK_EN
   always_comb begin
      align_ok_c = 1'b1;
      case (bus.reqFunct3[1:0])
         2'b01:   align_ok_c = ~bus.reqAddr[0];
         2'b10:   align_ok_c = (bus.reqAddr[1:0] == 2'b00);
         default: align_ok_c = 1'b1;
      endcase
   end
`else
   assign align_ok_c = 1'b1;
`endif

   // Lane extraction for loads; a half only looks at addr[1]
   always_comb begin
      byte_c     = 8'(bus.memReadData >> {op_lane, 3'b000});
      half_c     = 16'(bus.memReadData >> {op_lane[1], 4'b0000});
      load_ext_c = bus.memReadData;
      case (op_funct3)
         3'b000:  load_ext_c = {{24{byte_c[7]}}, byte_c};
         3'b001:  load_ext_c = {{16{half_c[15]}}, half_c};
         3'b100:  load_ext_c = {24'h000000, byte_c};
         3'b101:  load_ext_c = {16'h0000, half_c};
         default: load_ext_c = bus.memReadData;
      endcase
   end

   // Read-modify-write merge for SB/SH
   always_comb begin
      merged_c = bus.memReadData;
      if (op_funct3[1:0] == 2'b00) begin
         merged_c[{op_lane, 3'b000} +: 8] = op_data[7:0];
      end else begin
         merged_c[{op_lane[1], 4'b0000} +: 16] = op_data[15:0];
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept_c) begin
               if (err_c)                                          state_next = DONE;
               else if (bus.reqWrite && bus.reqFunct3 == 3'b010) state_next = WR;
               else                                                state_next = RD;
            end
         end
         RD:      state_next = CAP;
         CAP:     state_next = op_write ? WR : DONE;
         WR:      state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes/handshake are registered copies of the next state, so they track the state exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         op_write         <= 1'b0;
         op_funct3        <= 3'b000;
         op_lane          <= 2'b00;
         op_data          <= 16'h0000;
         bus.reqReady     <= 1'b1;
         bus.respValid    <= 1'b0;
         bus.respErr      <= 1'b0;
         bus.loadData     <= 32'h0;
         bus.memRead      <= 1'b0;
         bus.memWrite     <= 1'b0;
         bus.memAddr      <= '0;
         bus.memWriteData <= 32'h0;
      end else begin
         state         <= state_next;
         bus.reqReady  <= (state_next == IDLE);
         bus.respValid <= (state_next == DONE);
         bus.memRead   <= (state_next == RD);
         bus.memWrite  <= (state_next == WR);
         bus.respErr   <= accept_c && err_c;
         if (accept_c) begin
            op_write     <= bus.reqWrite;
            op_funct3    <= bus.reqFunct3;
            op_lane      <= bus.reqAddr[1:0];
            op_data      <= bus.reqData[15:0];
            bus.loadData <= 32'h0;
            bus.memAddr  <= {bus.reqAddr[ADDR_W-1:2], 2'b00};
            if (bus.reqWrite) bus.memWriteData <= bus.reqData;
         end
         if (state == CAP) begin
            if (op_write) bus.memWriteData <= merged_c;
            else          bus.loadData     <= load_ext_c;
         end
      end
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the single-port data memory interface. It accepts one load/store request at a time from the execute/memory stage and sequences the word-only data memory, which has 1-cycle registered reads and exclusive memWrite/memRead strobes. It performs RISC-V sub-word handling: LB/LH/LW/LBU/LHU extraction with sign or zero extension, and SB/SH via read-modify-write. It returns a one-cycle response with the load result or an error flag.

Parameters:
ADDR_W, 32, width of request and memory address buses
MEM_WORDS, 1024, number of 32-bit words in the data memory; byte addresses at or above MEM_WORDS*4 are out of range

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
reqValid  input  1  request present
reqReady  output  1  unit idle and able to accept a request
reqWrite  input  1  0=load, 1=store
reqFunct3  input  3  RISC-V funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
reqAddr  input  ADDR_W  byte address
reqData  input  32  store data; lane 0 holds the low bits
respValid  output  1  one-cycle completion pulse
respErr  output  1  valid with respValid; misaligned, out-of-range or illegal funct3
loadData  output  32  extended load result; valid with respValid
memWrite  output  1  data memory write strobe
memRead  output  1  data memory read strobe
memAddr  output  ADDR_W  word-aligned byte address; bits [1:0] always 0
memWriteData  output  32  full word to write
memReadData  input  32  memory read data, valid the cycle after memRead

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst, effective at the posedge where rst=1.
- Reset values: state IDLE, reqReady=1, respValid=0, respErr=0, loadData=0, memRead=0, memWrite=0, memAddr=0, memWriteData=0.
- Request handshake:
  - Accept when reqValid && reqReady. The request fields are latched at that edge.
  - reqReady=1 only in IDLE.
  - Request inputs are ignored while busy.
- FSM: IDLE, RD, CAP, WR, DONE.
  - IDLE, on accept:
    - error condition -> DONE with respErr=1
    - load or SB/SH -> RD
    - SW -> WR
  - RD: memRead=1, memAddr={addr[ADDR_W-1:2],2'b00}. Next state CAP.
  - CAP: memReadData is valid in this cycle.
    - Load: extract the byte/half at addr[1:0] and sign- or zero-extend it into loadData. Next state DONE.
    - SB/SH: merge reqData[7:0] or [15:0] into the lane selected by addr[1:0] and register the result in memWriteData. Next state WR.
  - WR: memWrite=1, memAddr aligned, memWriteData = merged word (SB/SH) or reqData (SW). Next state DONE.
  - DONE: respValid=1 for exactly one cycle. Next state IDLE; reqReady=1 in the following cycle.
- memRead and memWrite are Moore outputs of the state and are never high together.
- Latency from the accept edge to the respValid cycle:
  - loads: 3
  - SW: 2
  - SB/SH: 4
  - error: 1
- Errors (respErr=1): no memory strobe is issued, and loadData is held at 0.
  - addr >= MEM_WORDS*4
  - illegal funct3: load 011/110/111; store with funct3 >= 011
  - misalignment, per the Optional Feature section
- Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0]. Half at addr[1]=1 selects bits [31:16].
- Reset mid-operation: the in-flight operation is dropped. No further memRead/memWrite or respValid is issued, and the unit is in IDLE after the reset edge. A write already strobed stays committed.
- The unit never accepts and responds in the same cycle; back-to-back requests are spaced by the IDLE cycle.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, produce respErr=1 at latency 1 with no memory access.
- Undefined: the low address bits that would be misaligned are ignored. A half access uses addr[1] only; a word access uses the aligned word. No error is raised for alignment.

Test Plan:
1. Preload word 0x10 = 0x8899AABB. LW 0x10 -> memRead high 1 cycle after accept; respValid at accept+3, loadData=0x8899AABB, respErr=0.
2. Same memory. LB 0x10 -> 0xFFFFFFBB. LBU 0x13 -> 0x00000088. LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB.
3. SB 0x11, reqData=0x12345677 -> RD then WR with memWriteData=0x889977BB; memRead and memWrite never overlap; respValid at accept+4.
4. SH 0x12, reqData=0x0000CAFE -> written 0xCAFEAABB. SW 0x10, reqData=0xDEADBEEF -> single memWrite, no memRead, respValid at accept+2.
5. LW 0x12 with macro defined -> respErr=1 at accept+1, no strobes. Without the macro -> reads word 0x10. LW 0x1000 -> respErr=1 regardless of the macro. Load funct3=011 -> respErr=1.
6. Assert rst during CAP of an SB -> memWrite stays 0, respValid never pulses, reqReady=1 the cycle after the reset edge, and a following LW completes normally.
